mips_trace_buffer: RTL and testbench
====================================

Name: mips_trace_buffer

Overview:
- Parametrised hardware trace-capture block for the MIPS core; replaces fixed-time `$display` probing with cycle-accurate, synthesizable sampling.
- Samples NCH datapath channels (e.g. ALU_Result, Read_data, write-back mux, Instruction) plus the Zero flag.
- Sampling is controlled by a programmable schedule or trigger; samples are stored in a DEPTH-entry FIFO with cycle-stamps.
- Sits beside MIPS_TopModule; read out by the bench or a debug port.

Parameters:
- DATA_W, 32, width of each captured channel
- NCH, 4, number of captured channels per sample
- DEPTH, 16, FIFO entries; power of two, ≥2
- CNT_W, 16, width of cycle counter, start_cycle, period and rd_cycle

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  1-cycle pulse; starts a capture session
- abort  in  1  1-cycle pulse; ends the session, FIFO contents kept
- mode  in  2  0 one-shot, 1 periodic, 2 on-trigger, 3 continuous; sampled at arm
- start_cycle  in  CNT_W  first eligible cycle offset after arm; sampled at arm
- period  in  CNT_W  sample spacing in mode 1; 0 treated as 1; sampled at arm
- trig  in  1  qualifier for mode 2 (e.g. RegWrite)
- ch_in  in  NCH*DATA_W  channel data; channel 0 in the LSBs
- zero_in  in  1  ALU Zero flag, stored with each sample
- rd_en  in  1  pop request
- rd_data  out  NCH*DATA_W  popped channel data
- rd_zero  out  1  popped Zero flag
- rd_cycle  out  CNT_W  cycle-stamp of the popped sample
- rd_valid  out  1  rd_* valid for one cycle
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: a sample was lost or overwritten since arm
- busy  out  1  session active (WAIT or CAPTURE)

Behaviour:
- Reset (async, rst_n=0), all outputs 0 except empty=1:
  - state=IDLE, FIFO pointers 0, cyc=0.
- States:
  - IDLE: arm → WAIT. Latch mode, start_cycle and period. Set cyc=0. Clear FIFO and overflow.
  - WAIT: cyc increments every cycle. cyc==start_cycle → CAPTURE, and that cycle is eligible.
  - CAPTURE: cyc keeps incrementing. Eligible cycles:
    - mode 0: first cycle only.
    - mode 1: every period cycles starting at start_cycle.
    - mode 2: cycles with trig=1.
    - mode 3: every cycle.
  - Mode 0 → DONE after its one sample.
  - DONE: busy=0. arm → WAIT, clearing FIFO and overflow as from IDLE.
  - abort in WAIT or CAPTURE → DONE the next cycle; no sample taken on the abort cycle.
  - arm while busy is ignored.
- Capture: on an eligible cycle, ch_in, zero_in and cyc are written at that rising edge. count updates the same edge.
- Read: rd_en with empty=0 pops; rd_* are registered and rd_valid=1 the following cycle. rd_en with empty=1 is ignored (rd_valid=0).
- Simultaneous write and pop:
  - Not full: count unchanged.
  - Full: pop then write; no loss, overflow unchanged.
- Write when full and no pop: handled per the optional feature.
- cyc saturates at all-ones; it does not wrap.
- Pointers wrap modulo DEPTH.
- Reset mid-session: immediate IDLE, FIFO emptied, data lost.

Optional Feature:
- Macro: TRACE_STOP_ON_FULL_EN
- Defined:
  - Write to a full FIFO (no simultaneous pop) discards the new sample.
  - overflow=1; state → DONE on the same edge.
  - The oldest DEPTH samples are preserved.
- Undefined (ring mode):
  - Write to a full FIFO overwrites the oldest entry; the read pointer advances.
  - overflow=1; capture continues.
  - The newest DEPTH samples are preserved.

Test Plan:
- Periodic probe schedule: mode=1, start_cycle=12, period=4, arm, run 24 cycles, then abort.
  - Expected: 4 samples stamped 12, 16, 20, 24.
  - Popped data equals the ch_in values driven on those cycles.
- One-shot: mode=0, start_cycle=5.
  - Expected: exactly 1 sample, stamp 5; busy falls on cycle 6; count=1.
- Trigger: mode=2, start_cycle=0, trig high on cycles 3, 4 and 9.
  - Expected: 3 samples stamped 3, 4, 9; zero_in is captured per sample.
- Overflow: mode=3, DEPTH=16, 20 cycles, no reads.
  - Without macro: count=16, overflow=1, first pop stamp=4.
  - With TRACE_STOP_ON_FULL_EN: first pop stamp=0, state DONE after cycle 16.
- Full + simultaneous pop: fill to 16, then rd_en on a capture cycle.
  - Expected: count stays 16, overflow=0, popped stamp is the oldest.
- Async reset mid-CAPTURE: assert rst_n=0 between clock edges.
  - Expected: empty=1, count=0, busy=0, rd_valid=0 immediately; arm restarts cleanly.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// Cycle-stamped trace capture for the MIPS datapath: schedule/trigger FSM feeding a DEPTH-entry FIFO.
// Optional macro TRACE_STOP_ON_FULL_EN: stop on a full FIFO instead of overwriting the oldest sample.
module mips_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int NCH    = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [1:0]                mode,
  input  logic [CNT_W-1:0]          start_cycle,
  input  logic [CNT_W-1:0]          period,
  input  logic                      trig,
  input  logic [NCH*DATA_W-1:0]     ch_in,
  input  logic                      zero_in,
  input  logic                      rd_en,
  output logic [NCH*DATA_W-1:0]     rd_data,
  output logic                      rd_zero,
  output logic [CNT_W-1:0]          rd_cycle,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  localparam int SW    = NCH * DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CYC_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] start_q;
  logic [CNT_W-1:0] per_m1;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] cyc;

  logic [SW-1:0]    mem_data [DEPTH];
  logic             mem_zero [DEPTH];
  logic [CNT_W-1:0] mem_cyc  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic eligible;
  logic wr_req;
  logic wr_do;
  logic drop;
  logic overwrite;
  logic pop;
  logic rd_adv;
  logic clear;

  assign state_dbg = state;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign pop       = rd_en && !empty;
  assign clear     = arm && ((state == S_IDLE) || (state == S_DONE));

  // Start cycle is eligible for every mode except trigger mode, which still needs trig.
  always_comb begin
    eligible = 1'b0;
    case (state)
      S_WAIT: begin
        if (cyc == start_q) begin
          eligible = (mode_q == 2'd2) ? trig : 1'b1;
        end
      end
      S_CAPTURE: begin
        case (mode_q)
          2'd1:    eligible = (per_cnt == '0);
          2'd2:    eligible = trig;
          2'd3:    eligible = 1'b1;
          default: eligible = 1'b0;
        endcase
      end
      default: eligible = 1'b0;
    endcase
  end

  assign wr_req = eligible && !abort;

`ifdef TRACE_STOP_ON_FULL_EN
  assign wr_do     = wr_req && (!full || pop);
  assign drop      = wr_req && full && !pop;
  assign overwrite = 1'b0;
`else
  assign wr_do     = wr_req;
  assign drop      = 1'b0;
  assign overwrite = wr_req && full && !pop;
`endif

  assign rd_adv = pop || overwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      mode_q  <= 2'd0;
      start_q <= '0;
      per_m1  <= '0;
      per_cnt <= '0;
      cyc     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state   <= S_WAIT;
            busy    <= 1'b1;
            mode_q  <= mode;
            start_q <= start_cycle;
            per_m1  <= (period == '0) ? '0 : period - CYC_ONE;
            cyc     <= '0;
          end
        end
        S_WAIT: begin
          if (cyc != CYC_MAX) cyc <= cyc + CYC_ONE;
          if (abort) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end else if (cyc == start_q) begin
            per_cnt <= per_m1;
            if (mode_q == 2'd0) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (cyc != CYC_MAX) cyc <= cyc + CYC_ONE;
          // per_cnt counts down to the next periodic sample and reloads on it.
          if (per_cnt == '0) per_cnt <= per_m1;
          else               per_cnt <= per_cnt - CYC_ONE;
          if (abort || drop) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem_data[wr_ptr] <= ch_in;
      mem_zero[wr_ptr] <= zero_in;
      mem_cyc[wr_ptr]  <= cyc;
    end
  end

  // A pop and a write on the same edge keep count; a ring overwrite advances both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_zero  <= 1'b0;
      rd_cycle <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data  <= mem_data[rd_ptr];
        rd_zero  <= mem_zero[rd_ptr];
        rd_cycle <= mem_cyc[rd_ptr];
      end
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_do)  wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
        case ({wr_do, rd_adv})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
        if (drop || overwrite) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: schedules, trigger, overflow, full+pop and async reset.
module tb_mips_trace_buffer;

  localparam int DATA_W = 32;
  localparam int NCH    = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int SW     = NCH * DATA_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             arm;
  logic             abort;
  logic [1:0]       mode;
  logic [CNT_W-1:0] start_cycle;
  logic [CNT_W-1:0] period;
  logic             trig;
  logic [SW-1:0]    ch_in;
  logic             zero_in;
  logic             rd_en;
  logic [SW-1:0]    rd_data;
  logic             rd_zero;
  logic [CNT_W-1:0] rd_cycle;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [$clog2(DEPTH):0] count;
  logic             overflow;
  logic             busy;
  logic [1:0]       state_dbg;

  int total = 0;
  int bad   = 0;

  mips_trace_buffer #(
    .DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .mode(mode),
    .start_cycle(start_cycle), .period(period), .trig(trig), .ch_in(ch_in),
    .zero_in(zero_in), .rd_en(rd_en), .rd_data(rd_data), .rd_zero(rd_zero),
    .rd_cycle(rd_cycle), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] pat(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {32'hD000_0000 + kk, 32'hC000_0000 + kk, 32'hB000_0000 + kk, 32'hA000_0000 + kk};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] p);
    mode = m;
    start_cycle = s;
    period = p;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b want=0", full); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b want=0", overflow); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0b want=0", rd_valid); end
    total++; if (rd_cycle !== 16'd0) begin bad++; $display("FAIL rst_rd_cycle got=%0d want=0", rd_cycle); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%0h want=0", rd_data); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_dbg); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_periodic();
    int exp_st [4];
    exp_st = '{12, 16, 20, 24};
    do_arm(2'd1, 16'd12, 16'd4);
    for (int k = 0; k <= 24; k++) begin
      ch_in = pat(k);
      zero_in = 1'b0;
      // re-arm while busy with a different setup must be ignored
      if (k == 3) begin
        arm = 1'b1; mode = 2'd3; start_cycle = 16'd0;
      end else begin
        arm = 1'b0;
      end
      tick();
    end
    arm = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL per_busy got=%0b want=1", busy); end
    do_abort();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL per_abort_busy got=%0b want=0", busy); end
    total++; if (count !== 5'd4) begin bad++; $display("FAIL per_count got=%0d want=4", count); end
    for (int i = 0; i < 4; i++) begin
      do_pop();
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL per_valid%0d got=%0b want=1", i, rd_valid); end
      total++; if (rd_cycle !== 16'(exp_st[i])) begin bad++; $display("FAIL per_stamp%0d got=%0d want=%0d", i, rd_cycle, exp_st[i]); end
      total++; if (rd_data !== pat(exp_st[i])) begin bad++; $display("FAIL per_data%0d got=%0h want=%0h", i, rd_data, pat(exp_st[i])); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL per_empty got=%0b want=1", empty); end
    do_pop();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL per_pop_empty got=%0b want=0", rd_valid); end
  endtask

  task automatic test_one_shot();
    do_arm(2'd0, 16'd5, 16'd0);
    for (int k = 0; k <= 5; k++) begin
      ch_in = pat(100 + k);
      zero_in = 1'b1;
      if (k == 4) begin
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL os_wait_state got=%0d want=1", state_dbg); end
      end
      if (k == 5) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_busy5 got=%0b want=1", busy); end
      end
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_busy6 got=%0b want=0", busy); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL os_count got=%0d want=1", count); end
    total++; if (state_dbg !== 2'd3) begin bad++; $display("FAIL os_state got=%0d want=3", state_dbg); end
    do_pop();
    total++; if (rd_cycle !== 16'd5) begin bad++; $display("FAIL os_stamp got=%0d want=5", rd_cycle); end
    total++; if (rd_data !== pat(105)) begin bad++; $display("FAIL os_data got=%0h want=%0h", rd_data, pat(105)); end
    total++; if (rd_zero !== 1'b1) begin bad++; $display("FAIL os_zero got=%0b want=1", rd_zero); end
  endtask

  task automatic test_trigger();
    int   exp_st [3];
    logic exp_z  [3];
    exp_st = '{3, 4, 9};
    exp_z  = '{1'b1, 1'b0, 1'b1};
    do_arm(2'd2, 16'd0, 16'd0);
    for (int k = 0; k < 12; k++) begin
      ch_in = pat(200 + k);
      trig = (k == 3) || (k == 4) || (k == 9);
      zero_in = ((k % 3) == 0);
      tick();
    end
    trig = 1'b0;
    do_abort();
    total++; if (count !== 5'd3) begin bad++; $display("FAIL trg_count got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      do_pop();
      total++; if (rd_cycle !== 16'(exp_st[i])) begin bad++; $display("FAIL trg_stamp%0d got=%0d want=%0d", i, rd_cycle, exp_st[i]); end
      total++; if (rd_zero !== exp_z[i]) begin bad++; $display("FAIL trg_zero%0d got=%0b want=%0b", i, rd_zero, exp_z[i]); end
      total++; if (rd_data !== pat(200 + exp_st[i])) begin bad++; $display("FAIL trg_data%0d got=%0h want=%0h", i, rd_data, pat(200 + exp_st[i])); end
    end
  endtask

  task automatic test_overflow();
    logic [1:0]       exp_state17;
    logic [CNT_W-1:0] exp_first;
`ifdef TRACE_STOP_ON_FULL_EN
    exp_state17 = 2'd3;
    exp_first   = 16'd0;
`else
    exp_state17 = 2'd2;
    exp_first   = 16'd4;
`endif
    do_arm(2'd3, 16'd0, 16'd0);
    for (int k = 0; k < 20; k++) begin
      ch_in = pat(300 + k);
      zero_in = 1'b0;
      if (k == 16) begin
        total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL ovf_state16 got=%0d want=2", state_dbg); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_flag16 got=%0b want=0", overflow); end
      end
      if (k == 17) begin
        total++; if (state_dbg !== exp_state17) begin bad++; $display("FAIL ovf_state17 got=%0d want=%0d", state_dbg, exp_state17); end
      end
      tick();
    end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", count); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b want=1", full); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
    do_abort();
    do_pop();
    total++; if (rd_cycle !== exp_first) begin bad++; $display("FAIL ovf_first_stamp got=%0d want=%0d", rd_cycle, exp_first); end
    total++; if (rd_data !== pat(300 + int'(exp_first))) begin bad++; $display("FAIL ovf_first_data got=%0h want=%0h", rd_data, pat(300 + int'(exp_first))); end
  endtask

  task automatic test_full_pop();
    do_arm(2'd3, 16'd0, 16'd0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL fp_cleared got=%0d want=0", count); end
    for (int k = 0; k < 16; k++) begin
      ch_in = pat(400 + k);
      tick();
    end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fp_fill got=%0d want=16", count); end
    ch_in = pat(416);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    abort = 1'b1;
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL fp_valid got=%0b want=1", rd_valid); end
    total++; if (rd_cycle !== 16'd0) begin bad++; $display("FAIL fp_stamp got=%0d want=0", rd_cycle); end
    total++; if (rd_data !== pat(400)) begin bad++; $display("FAIL fp_data got=%0h want=%0h", rd_data, pat(400)); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fp_count got=%0d want=16", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%0b want=0", overflow); end
    tick();
    abort = 1'b0;
    do_pop();
    total++; if (rd_cycle !== 16'd1) begin bad++; $display("FAIL fp_next_stamp got=%0d want=1", rd_cycle); end
  endtask

  task automatic test_period_zero();
    do_arm(2'd1, 16'd2, 16'd0);
    for (int k = 0; k <= 4; k++) begin
      ch_in = pat(500 + k);
      tick();
    end
    do_abort();
    total++; if (count !== 5'd3) begin bad++; $display("FAIL pz_count got=%0d want=3", count); end
    do_pop();
    total++; if (rd_cycle !== 16'd2) begin bad++; $display("FAIL pz_stamp got=%0d want=2", rd_cycle); end
  endtask

  task automatic test_async_reset();
    do_arm(2'd3, 16'd0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      ch_in = pat(600 + k);
      tick();
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%0b want=1", rd_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ar_empty got=%0b want=1", empty); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL ar_count got=%0d want=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%0b want=0", busy); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0b want=0", rd_valid); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL ar_state got=%0d want=0", state_dbg); end
    #1 rst_n = 1'b1;
    tick();
    do_arm(2'd0, 16'd2, 16'd0);
    for (int k = 0; k <= 2; k++) begin
      ch_in = pat(700 + k);
      tick();
    end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL ar_rearm_count got=%0d want=1", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_rearm_busy got=%0b want=0", busy); end
    do_pop();
    total++; if (rd_cycle !== 16'd2) begin bad++; $display("FAIL ar_rearm_stamp got=%0d want=2", rd_cycle); end
    total++; if (rd_data !== pat(702)) begin bad++; $display("FAIL ar_rearm_data got=%0h want=%0h", rd_data, pat(702)); end
  endtask

  initial begin
    arm = 1'b0;
    abort = 1'b0;
    mode = 2'd0;
    start_cycle = '0;
    period = '0;
    trig = 1'b0;
    ch_in = '0;
    zero_in = 1'b0;
    rd_en = 1'b0;
    test_reset();
    test_periodic();
    test_one_shot();
    test_trigger();
    test_overflow();
    test_full_pop();
    test_period_zero();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
